systolic_mac_ctrl: RTL and testbench

Sequencer for an N×N systolic array of `element` MAC processing elements (PEs) computing C = A·B with inner dimension K. On a start pulse the block does four things in order. It clears the PE accumulators. It drives skewed per-lane read addresses and valid masks to the A-row and B-column operand buffers. It waits for the wavefront to flush through the array. It then drains C one row per handshake to the result writer. It sits between the operand buffers, the PE array wrapper and the output buffer.

---
 rtl/systolic_pkg.sv | 40 ++++
 rtl/systolic_skew_gen.sv | 38 +++
 rtl/systolic_mac_ctrl.sv | 178 +++++++++++++++++
 tb/tb_systolic_mac_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared state encoding and sizing helpers for the systolic
//                array MAC sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Bits needed to index n items, never less than one so N=1 still has a port.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Number of feed steps: t runs 0..K+N-2.
    function automatic int feed_len(input int k, input int n);
        return k + n - 1;
    endfunction

    // Cycles needed for the last wavefront to cross the array after feeding stops.
    function automatic int flush_len(input int n);
        return n - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_skew_gen.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_skew_gen
//  Description : Combinational skew generator. For feed step t, lane i is
//                valid while i <= t < K+i and reads operand address t-i;
//                invalid lanes present address 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_gen
    import systolic_pkg::*;
#(
    parameter int array_size = 4,
    parameter int k_width    = 8,
    parameter int t_width    = 11
) (
    input  logic [t_width-1:0]            t,
    input  logic [k_width-1:0]            k,
    input  logic                          en,
    output logic [array_size-1:0]         vld,
    output logic [array_size*k_width-1:0] addr
);

    for (genvar i = 0; i < array_size; i++) begin : g_lane
        logic [t_width-1:0] w_lo;
        logic [t_width-1:0] w_hi;
        logic               w_on;

        // Lane i lags lane 0 by i steps and stays live for exactly K steps.
        assign w_lo = t_width'(i);
        assign w_hi = t_width'(k) + w_lo;
        assign w_on = en && (t >= w_lo) && (t < w_hi);

        assign vld[i]                     = w_on;
        assign addr[i*k_width +: k_width] = w_on ? k_width'(t - w_lo) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/systolic_mac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_mac_ctrl
//  Description : Job sequencer for an NxN systolic MAC array: clears the PEs,
//                feeds skewed A/B operand addresses, waits for the wavefront
//                to flush, then drains C one row per handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_mac_ctrl
    import systolic_pkg::*;
#(
    parameter int data_size  = 8,
    parameter int array_size = 4,
    parameter int k_width    = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [k_width-1:0]                       k_len,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     pe_clear,
    output logic [array_size-1:0]                    a_vld,
    output logic [array_size-1:0]                    b_vld,
    output logic [array_size*k_width-1:0]            a_addr,
    output logic [array_size*k_width-1:0]            b_addr,
    output logic [clog2_min1(array_size)-1:0]        c_row_sel,
    output logic                                     c_vld,
    input  logic                                     c_ready
);

    localparam int c_row_w   = clog2_min1(array_size);
    localparam int c_t_w     = k_width + c_row_w + 1;
    localparam int c_flush_w = c_row_w;

    // Operand width only sizes the PE accumulators outside this block; the
    // sequencer itself is width-agnostic, so this gate is always empty.
    if (data_size < 1 || array_size < 1) begin : g_param_guard
    end

    state_t                 r_state;
    logic [k_width-1:0]     r_k;
    logic [c_t_w-1:0]       r_t;
    logic [c_flush_w-1:0]   r_flush;
    logic [c_row_w-1:0]     r_row;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_clear;
    logic                   r_cvld;

    logic [c_t_w-1:0]       w_feed_last;
    logic [c_flush_w-1:0]   w_flush_last;
    logic [c_row_w-1:0]     w_row_last;
    logic                   w_feed_en;

    assign w_feed_last  = c_t_w'(feed_len(int'(r_k), array_size) - 1);
    assign w_flush_last = c_flush_w'(flush_len(array_size) - 1);
    assign w_row_last   = c_row_w'(array_size - 1);
    assign w_feed_en    = (r_state == ST_FEED);

    // Job FSM with its counters and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_t     <= '0;
            r_flush <= '0;
            r_row   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_clear <= 1'b0;
            r_cvld  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_k     <= k_len;
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_clear <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_clear <= 1'b0;
                    r_t     <= '0;
                    if (r_k == '0) begin
                        // Empty inner dimension: the cleared PEs already hold C.
                        r_state <= ST_DRAIN;
                        r_cvld  <= 1'b1;
                        r_row   <= '0;
                    end else begin
                        r_state <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (r_t == w_feed_last) begin
                        r_t <= '0;
                        if (array_size == 1) begin
                            r_state <= ST_DRAIN;
                            r_cvld  <= 1'b1;
                            r_row   <= '0;
                        end else begin
                            r_state <= ST_FLUSH;
                            r_flush <= '0;
                        end
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush == w_flush_last) begin
                        r_state <= ST_DRAIN;
                        r_cvld  <= 1'b1;
                        r_row   <= '0;
                    end else begin
                        r_flush <= r_flush + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_cvld && c_ready) begin
                        if (r_row == w_row_last) begin
                            r_state <= ST_DONE;
                            r_cvld  <= 1'b0;
                            r_done  <= 1'b1;
                            r_row   <= '0;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_clear <= 1'b0;
                    r_cvld  <= 1'b0;
                end
            endcase
        end
    end

    systolic_skew_gen #(
        .array_size (array_size),
        .k_width    (k_width),
        .t_width    (c_t_w)
    ) u_skew_a (
        .t    (r_t),
        .k    (r_k),
        .en   (w_feed_en),
        .vld  (a_vld),
        .addr (a_addr)
    );

    systolic_skew_gen #(
        .array_size (array_size),
        .k_width    (k_width),
        .t_width    (c_t_w)
    ) u_skew_b (
        .t    (r_t),
        .k    (r_k),
        .en   (w_feed_en),
        .vld  (b_vld),
        .addr (b_addr)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign pe_clear  = r_clear;
    assign c_vld     = r_cvld;
    assign c_row_sel = r_row;

endmodule
`default_nettype wire

// File: tb/tb_systolic_mac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_mac_ctrl
//  Description : Directed, table-driven bench for systolic_mac_ctrl (N=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_mac_ctrl;

    localparam int N  = 4;
    localparam int KW = 8;
    localparam int RW = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              busy;
    logic              done;
    logic              pe_clear;
    logic [N-1:0]      a_vld;
    logic [N-1:0]      b_vld;
    logic [N*KW-1:0]   a_addr;
    logic [N*KW-1:0]   b_addr;
    logic [RW-1:0]     c_row_sel;
    logic              c_vld;
    logic              c_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int k;
        int stall_row;
        int stall_len;
        int glitch_cyc;
        int glitch_k;
        int exp_done;
        int exp_vld_cycles;
        int exp_vld_total;
    } vec_t;

    vec_t tbl [8];

    systolic_mac_ctrl #(
        .data_size  (8),
        .array_size (N),
        .k_width    (KW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .pe_clear  (pe_clear),
        .a_vld     (a_vld),
        .b_vld     (b_vld),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .c_row_sel (c_row_sel),
        .c_vld     (c_vld),
        .c_ready   (c_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected lane mask for sample cycle cyc of a job with inner dimension k.
    function automatic logic [N-1:0] f_vld(input int cyc, input int k);
        logic [N-1:0] v;
        int t;
        v = '0;
        t = cyc - 2;
        if (k > 0 && cyc >= 2 && cyc <= k + N) begin
            for (int i = 0; i < N; i++) begin
                if (t >= i && t < k + i) v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [N*KW-1:0] f_addr(input int cyc, input int k);
        logic [N*KW-1:0] a;
        int t;
        a = '0;
        t = cyc - 2;
        if (k > 0 && cyc >= 2 && cyc <= k + N) begin
            for (int i = 0; i < N; i++) begin
                if (t >= i && t < k + i) a[i*KW +: KW] = KW'(t - i);
            end
        end
        return a;
    endfunction

    task automatic run_job(input vec_t v, input string tag);
        int  exp_row;
        int  stalls;
        int  done_cnt;
        int  done_at;
        int  vld_cycles;
        int  vld_total;
        int  drain_start;
        logic in_drain;
        exp_row     = 0;
        stalls      = 0;
        done_cnt    = 0;
        done_at     = -1;
        vld_cycles  = 0;
        vld_total   = 0;
        drain_start = (v.k == 0) ? 2 : v.k + 2 * N;

        @(negedge clk);
        start   = 1'b1;
        k_len   = v.k[KW-1:0];
        c_ready = 1'b1;
        for (int cyc = 1; cyc <= v.exp_done + 1; cyc++) begin
            @(negedge clk);
            in_drain = (cyc >= drain_start) && (cyc < v.exp_done);
            check({tag, " a_vld"},    64'(a_vld),    64'(f_vld(cyc, v.k)));
            check({tag, " b_vld"},    64'(b_vld),    64'(f_vld(cyc, v.k)));
            check({tag, " a_addr"},   64'(a_addr),   64'(f_addr(cyc, v.k)));
            check({tag, " b_addr"},   64'(b_addr),   64'(f_addr(cyc, v.k)));
            check({tag, " busy"},     64'(busy),     64'(cyc <= v.exp_done));
            check({tag, " pe_clear"}, 64'(pe_clear), 64'(cyc == 1));
            check({tag, " c_vld"},    64'(c_vld),    64'(in_drain));
            if (in_drain) check({tag, " c_row_sel"}, 64'(c_row_sel), 64'(exp_row));
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
            if (a_vld != '0) vld_cycles++;
            vld_total += $countones(a_vld);

            start = (cyc == v.glitch_cyc);
            if (cyc == v.glitch_cyc) k_len = v.glitch_k[KW-1:0];
            c_ready = 1'b1;
            if (in_drain && exp_row == v.stall_row && stalls < v.stall_len) begin
                c_ready = 1'b0;
                stalls++;
            end
            if (in_drain && c_ready) exp_row++;
        end
        start   = 1'b0;
        c_ready = 1'b1;
        check({tag, " done_count"},  64'(done_cnt),   64'(1));
        check({tag, " done_cycle"},  64'(done_at),    64'(v.exp_done));
        check({tag, " vld_cycles"},  64'(vld_cycles), 64'(v.exp_vld_cycles));
        check({tag, " vld_total"},   64'(vld_total),  64'(v.exp_vld_total));
    endtask

    initial begin
        vec_t rv;
        //           k   srow slen gcyc gk  done vcyc vtot
        tbl[0] = '{  4,  -1,  0,  -1,  0,  16,   7,  16};
        tbl[1] = '{  1,  -1,  0,  -1,  0,  13,   4,   4};
        tbl[2] = '{  0,  -1,  0,  -1,  0,   6,   0,   0};
        tbl[3] = '{  4,   1,  2,  -1,  0,  18,   7,  16};
        tbl[4] = '{  4,  -1,  0,   4,  9,  16,   7,  16};
        tbl[5] = '{  2,  -1,  0,  14,  5,  14,   5,   8};
        tbl[6] = '{  7,   3,  1,  -1,  0,  20,  10,  28};
        tbl[7] = '{255,  -1,  0,  -1,  0, 267, 258, 1020};

        reset   = 1'b0;
        start   = 1'b0;
        k_len   = '0;
        c_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", 64'({busy, done, pe_clear, c_vld, c_row_sel, a_vld, b_vld}), 64'(0));
        check("reset_addr",  64'({a_addr, b_addr}), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 8; n++) begin
            run_job(tbl[n], $sformatf("vec%0d", n));
        end

        // Reset in the middle of FLUSH (cycles 9..11 for K=4).
        @(negedge clk);
        start = 1'b1;
        k_len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'(1));
        reset = 1'b0;
        #1;
        check("async_reset_ctrl", 64'({busy, done, pe_clear, c_vld, c_row_sel, a_vld, b_vld}), 64'(0));
        check("async_reset_addr", 64'({a_addr, b_addr}), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_no_done", 64'({done, busy}), 64'(0));
        end
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'(busy), 64'(0));
        rv = '{3, -1, 0, -1, 0, 15, 6, 12};
        run_job(rv, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
